// File: rtl/ifm_row_scheduler.sv
// ifm_row_scheduler
//
// Schedules a frame of input-feature-map rows into four row banks used as a
// ring. Incoming words are written row by row into bank wb; a consumer
// drains bank rb word by word. A bank is marked full when its row is
// complete and freed again when the consumer has read the whole row. This
// lets writing run ahead of reading by up to four rows.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_na         asynchronous active-low reset
//   start          one-cycle frame start request (honoured only in IDLE)
//   s_valid/s_data incoming IFM word stream; s_ready is the accept signal
//   wr_en          one-hot bank write strobe, qualified by the handshake
//   wr_addr        shared bank write address
//   wr_data        shared bank write data (pass-through of s_data)
//   rd_en          per-bank read strobes from the consumer
//   rd_addr        shared bank read address
//   ifm_bram_full  per-bank "complete unread row" flags
//   height_hs      one-cycle pulse after a row has been fully consumed
//   frame_done     one-cycle pulse after the last row of a frame is consumed
//   rd_err         sticky flag for an illegal read strobe

module ifm_row_scheduler #(
  parameter int RAM_WIDTH  = 64,
  parameter int ROW_WORDS  = 11,
  parameter int FRAME_ROWS = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_na,
  input  logic                 start,
  input  logic                 s_valid,
  input  logic [RAM_WIDTH-1:0] s_data,
  output logic                 s_ready,
  output logic [3:0]           wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [RAM_WIDTH-1:0] wr_data,
  input  logic [3:0]           rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [3:0]           ifm_bram_full,
  output logic                 height_hs,
  output logic                 frame_done,
  output logic                 rd_err
);

  // Row counters must hold the value FRAME_ROWS itself without wrapping.
  localparam int CNT_W = (FRAME_ROWS < 2) ? 1 : $clog2(FRAME_ROWS + 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ROW_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_ROW  = CNT_W'(FRAME_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        wb_r;
  logic [1:0]        rb_r;
  logic [ADDR_W-1:0] wr_idx_r;
  logic [ADDR_W-1:0] rd_idx_r;
  logic [CNT_W-1:0]  rows_wr_r;
  logic [CNT_W-1:0]  rows_rd_r;
  logic [3:0]        full_r;
  logic              height_hs_r;
  logic              frame_done_r;
  logic              rd_err_r;

  logic              start_ok_s;
  logic              s_ready_s;
  logic              wr_acc_s;
  logic              wr_row_done_s;
  logic              rd_acc_s;
  logic              rd_row_done_s;
  logic              rd_bad_s;
  logic              frame_wr_last_s;
  logic              frame_rd_last_s;
  logic [3:0]        full_set_s;
  logic [3:0]        full_clr_s;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  // Handshake qualifiers. s_ready depends on registers only, so there is no
  // combinational path from s_valid or rd_en into it.
  assign start_ok_s      = start && (state_r == IDLE);
  assign s_ready_s       = (state_r == FILL) && !full_r[wb_r];
  assign wr_acc_s        = s_valid && s_ready_s;
  assign wr_row_done_s   = wr_acc_s && (wr_idx_r == LAST_WORD);
  // A read is legal only as an exact one-hot strobe on the current read bank
  // while that bank holds a complete row; anything else nonzero is an error.
  assign rd_acc_s        = (state_r != IDLE) && (rd_en == onehot4(rb_r)) && full_r[rb_r];
  assign rd_row_done_s   = rd_acc_s && (rd_idx_r == LAST_WORD);
  assign rd_bad_s        = (rd_en != 4'b0000) && !rd_acc_s;
  assign frame_wr_last_s = wr_row_done_s && (rows_wr_r == LAST_ROW);
  assign frame_rd_last_s = rd_row_done_s && (rows_rd_r == LAST_ROW);
  // Set and clear masks never hit the same bank: writes are blocked on a full bank.
  assign full_set_s      = wr_row_done_s ? onehot4(wb_r) : 4'b0000;
  assign full_clr_s      = rd_row_done_s ? onehot4(rb_r) : 4'b0000;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_na) begin
    if (!rst_na) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL: begin
        if (frame_wr_last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FILL;
        end
      end
      DRAIN: begin
        if (frame_rd_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Bank pointers, word indices, row counters, full flags and status pulses.
  always_ff @(posedge clk or negedge rst_na) begin
    if (!rst_na) begin
      wb_r         <= 2'd0;
      rb_r         <= 2'd0;
      wr_idx_r     <= '0;
      rd_idx_r     <= '0;
      rows_wr_r    <= '0;
      rows_rd_r    <= '0;
      full_r       <= 4'b0000;
      height_hs_r  <= 1'b0;
      frame_done_r <= 1'b0;
      rd_err_r     <= 1'b0;
    end else if (start_ok_s) begin
      wb_r         <= 2'd0;
      rb_r         <= 2'd0;
      wr_idx_r     <= '0;
      rd_idx_r     <= '0;
      rows_wr_r    <= '0;
      rows_rd_r    <= '0;
      full_r       <= 4'b0000;
      height_hs_r  <= 1'b0;
      frame_done_r <= 1'b0;
      // Any strobe in IDLE is illegal, so a strobe coinciding with start still flags.
      rd_err_r     <= rd_bad_s;
    end else begin
      height_hs_r  <= rd_row_done_s;
      frame_done_r <= frame_rd_last_s;
      full_r       <= (full_r | full_set_s) & ~full_clr_s;
      if (rd_bad_s) begin
        rd_err_r <= 1'b1;
      end
      if (wr_acc_s) begin
        if (wr_idx_r == LAST_WORD) begin
          wr_idx_r  <= '0;
          wb_r      <= wb_r + 2'd1;
          rows_wr_r <= rows_wr_r + CNT_W'(1);
        end else begin
          wr_idx_r  <= wr_idx_r + ADDR_W'(1);
        end
      end
      if (rd_acc_s) begin
        if (rd_idx_r == LAST_WORD) begin
          rd_idx_r  <= '0;
          rb_r      <= rb_r + 2'd1;
          rows_rd_r <= rows_rd_r + CNT_W'(1);
        end else begin
          rd_idx_r  <= rd_idx_r + ADDR_W'(1);
        end
      end
    end
  end

  assign s_ready       = s_ready_s;
  assign wr_en         = wr_acc_s ? onehot4(wb_r) : 4'b0000;
  assign wr_addr       = wr_idx_r;
  assign wr_data       = s_data;
  assign rd_addr       = rd_idx_r;
  assign ifm_bram_full = full_r;
  assign height_hs     = height_hs_r;
  assign frame_done    = frame_done_r;
  assign rd_err        = rd_err_r;

endmodule

// File: doc/ifm_row_scheduler.md
IFM_ROW_SCHEDULER -- requirements
Module: ifm_row_scheduler

Interface
REQ-001 Parameter RAM_WIDTH, default 64, word width of each IFM row bank.
REQ-002 Parameter ROW_WORDS, default 11, words per image row (one row per bank fill).
REQ-003 Parameter FRAME_ROWS, default 8, rows per frame; legal range 1..255.
REQ-004 Parameter ADDR_W, default 4, bank address width; 2^ADDR_W >= ROW_WORDS.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_na  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle frame start request.
REQ-008 s_valid  input  1  incoming IFM word valid.
REQ-009 s_data  input  RAM_WIDTH  incoming IFM word.
REQ-010 s_ready  output  1  scheduler accepts s_data this cycle.
REQ-011 wr_en  output  4  one-hot write strobe to banks 0..3.
REQ-012 wr_addr  output  ADDR_W  write address, shared by all banks.
REQ-013 wr_data  output  RAM_WIDTH  write data, equal to s_data.
REQ-014 rd_en  input  4  per-bank read strobes from row-buffer consumer.
REQ-015 rd_addr  output  ADDR_W  read address, shared by all banks.
REQ-016 ifm_bram_full  output  4  bank n holds a complete unread row.
REQ-017 height_hs  output  1  one-cycle pulse: a row fully consumed, consumer advances bank.
REQ-018 frame_done  output  1  one-cycle pulse: all FRAME_ROWS written and consumed.
REQ-019 rd_err  output  1  sticky: illegal read strobe seen; cleared only by reset or start.

Function
REQ-020 FSM states IDLE, FILL, DRAIN; IDLE->FILL on start; FILL->DRAIN when rows_written reaches FRAME_ROWS; DRAIN->IDLE when rows_read reaches FRAME_ROWS, with frame_done pulsed in the cycle after that transition edge.
REQ-021 start outside IDLE is ignored; start in IDLE clears wb, rb, wr_addr, rd_addr, row counters, full flags, rd_err.
REQ-022 s_ready = (state==FILL) and not ifm_bram_full[wb], from registered state only (no combinational path from s_valid or rd_en).
REQ-023 Write accepted when s_valid and s_ready; wr_en = one-hot(wb) gated by acceptance; wr_data = s_data; wr_addr = current write index.
REQ-024 Write index increments per accepted word; at ROW_WORDS-1 it wraps to 0, ifm_bram_full[wb] sets on that edge, wb advances mod 4 (3->0), rows_written increments.
REQ-025 Read accepted when rd_en is exactly one-hot(rb) and ifm_bram_full[rb]=1; rd_addr = current read index.
REQ-026 Read index increments per accepted read; at ROW_WORDS-1 it wraps to 0, ifm_bram_full[rb] clears, rb advances mod 4, rows_read increments, height_hs =1 for the next cycle only.
REQ-027 rd_en nonzero but not accepted (wrong bank, multiple bits, bank not full, or state IDLE) sets rd_err and changes no other state.
REQ-028 Set of full[wb] and clear of full[rb] on the same edge both take effect; same-bank set/clear cannot occur (write blocked while full).
REQ-029 Banks refill as soon as freed: with all four banks full, s_ready stays 0 until the height_hs-causing edge, then rises the following cycle.
REQ-030 Reads continue in FILL and DRAIN; rows_read never exceeds rows_written.
REQ-031 Counters sized for FRAME_ROWS; no wrap within a frame.

Reset
REQ-032 rst_na low asynchronously forces: state IDLE, s_ready 0, wr_en 0, wr_addr 0, rd_addr 0, ifm_bram_full 0, height_hs 0, frame_done 0, rd_err 0, wb=rb=0, counters 0.
REQ-033 Reset mid-frame discards all buffered rows; no height_hs or frame_done is emitted for the aborted frame.

Verification
REQ-034 start, s_valid held 1, no reads -> 44 words written, ifm_bram_full=4'b1111 after word 44, s_ready=0 thereafter.
REQ-035 Then rd_en=4'b0001 for 11 cycles -> rd_addr 0..10, ifm_bram_full[0] clears, height_hs one pulse, s_ready=1 next cycle, next write to bank 0 addr 0.
REQ-036 Full 8-row frame with continuous streaming and reading -> exactly 8 height_hs pulses, banks used 0,1,2,3,0,1,2,3, one frame_done, state IDLE.
REQ-037 rd_en=4'b0010 while rb=0, and rd_en=4'b0011 -> rd_err=1, rd_addr and full flags unchanged; next start clears rd_err.
REQ-038 rst_na pulsed low mid-row (write index 5, two banks full) -> all outputs at reset values immediately; fresh start refills from bank 0 addr 0.
REQ-039 start asserted during FILL -> ignored, counters and flags unchanged.
